// File: rtl/pspl_axil_regs.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit R/W registers with a per-register write pulse.
// Write and read channels are independent FSMs, each with one outstanding transaction.
module pspl_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                                   s00_axi_aclk,
   input  logic                                   s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
   input  logic [2:0]                             s00_axi_awprot,
   input  logic                                   s00_axi_awvalid,
   output logic                                   s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
   input  logic                                   s00_axi_wvalid,
   output logic                                   s00_axi_wready,
   output logic [1:0]                             s00_axi_bresp,
   output logic                                   s00_axi_bvalid,
   input  logic                                   s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
   input  logic [2:0]                             s00_axi_arprot,
   input  logic                                   s00_axi_arvalid,
   output logic                                   s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
   output logic [1:0]                             s00_axi_rresp,
   output logic                                   s00_axi_rvalid,
   input  logic                                   s00_axi_rready,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
   output logic [NUM_REGS-1:0]                    wr_pulse,
   output logic [1:0]                             dbg_wr_state_o,
   output logic                                   dbg_rd_state_o
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int STRBW = C_S_AXI_DATA_WIDTH / 8;
   localparam int IDXW  = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [IDXW:0] NUM_REGS_L = NUM_REGS[IDXW:0];
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_e;
   typedef enum logic {R_IDLE, R_RESP} rd_state_e;

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   logic [DW-1:0]    regs_q [NUM_REGS];
   logic [IDXW-1:0]  aw_idx_q;
   logic [DW-1:0]    w_data_q;
   logic [STRBW-1:0] w_strb_q;
   logic             bvalid_q;
   logic [1:0]       bresp_q;
   logic [NUM_REGS-1:0] wr_pulse_q;
   logic             rvalid_q;
   logic [1:0]       rresp_q;
   logic [DW-1:0]    rdata_q;

   logic             awready_int, wready_int, arready_int;
   logic             commit;
   logic [IDXW-1:0]  commit_idx;
   logic [DW-1:0]    commit_data;
   logic [STRBW-1:0] commit_strb;
   logic             commit_ok;
   logic [IDXW-1:0]  aw_idx_in, ar_idx_in;
   logic             ar_ok;
   logic [DW-1:0]    rd_sel;
   logic             unused_ok;

   assign aw_idx_in = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign ar_idx_in = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // valid is never gated by ready, and responses hold stable until accepted.

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) wr_state_q <= W_IDLE;
      else                wr_state_q <= wr_state_d;
   end

   // Commit takes address/data from the channel firing now or from the latched copy.
   always_comb begin
      wr_state_d  = wr_state_q;
      awready_int = 1'b0;
      wready_int  = 1'b0;
      commit      = 1'b0;
      commit_idx  = aw_idx_in;
      commit_data = s00_axi_wdata;
      commit_strb = s00_axi_wstrb;
      case (wr_state_q)
         W_IDLE: begin
            awready_int = 1'b1;
            wready_int  = 1'b1;
            if (s00_axi_awvalid && s00_axi_wvalid) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end else if (s00_axi_awvalid) begin
               wr_state_d = W_HAVE_AW;
            end else if (s00_axi_wvalid) begin
               wr_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            wready_int = 1'b1;
            commit_idx = aw_idx_q;
            if (s00_axi_wvalid) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_HAVE_W: begin
            awready_int = 1'b1;
            commit_data = w_data_q;
            commit_strb = w_strb_q;
            if (s00_axi_awvalid) begin
               commit     = 1'b1;
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s00_axi_bready) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   assign commit_ok = ({1'b0, commit_idx} < NUM_REGS_L);

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         aw_idx_q   <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         wr_pulse_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         wr_pulse_q <= '0;
         if (s00_axi_awvalid && awready_int) aw_idx_q <= aw_idx_in;
         if (s00_axi_wvalid && wready_int) begin
            w_data_q <= s00_axi_wdata;
            w_strb_q <= s00_axi_wstrb;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= commit_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (bvalid_q && s00_axi_bready) begin
            bvalid_q <= 1'b0;
         end
         // Out-of-range indices match no i, so they leave storage and pulses untouched.
         for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && (commit_idx == IDXW'(i))) begin
               wr_pulse_q[i] <= 1'b1;
               for (int b = 0; b < STRBW; b++) begin
                  if (commit_strb[b]) regs_q[i][8*b +: 8] <= commit_data[8*b +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) rd_state_q <= R_IDLE;
      else                rd_state_q <= rd_state_d;
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      arready_int = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            arready_int = 1'b1;
            if (s00_axi_arvalid) rd_state_d = R_RESP;
         end
         R_RESP: begin
            if (s00_axi_rready) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   assign ar_ok = ({1'b0, ar_idx_in} < NUM_REGS_L);

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ar_idx_in == IDXW'(i)) rd_sel = regs_q[i];
      end
   end

   // Sampling regs_q here gives the pre-write value when a commit lands on the same edge.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_areset) begin
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else if (s00_axi_arvalid && arready_int) begin
         rvalid_q <= 1'b1;
         rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
         rdata_q  <= rd_sel;
      end else if (rvalid_q && s00_axi_rready) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s00_axi_awready = awready_int & ~s00_axi_areset;
   assign s00_axi_wready  = wready_int & ~s00_axi_areset;
   assign s00_axi_arready = arready_int & ~s00_axi_areset;
   assign s00_axi_bvalid  = bvalid_q;
   assign s00_axi_bresp   = bresp_q;
   assign s00_axi_rvalid  = rvalid_q;
   assign s00_axi_rresp   = rresp_q;
   assign s00_axi_rdata   = rdata_q;
   assign wr_pulse        = wr_pulse_q;
   assign dbg_wr_state_o  = wr_state_q;
   assign dbg_rd_state_o  = rd_state_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign regs_out[DW*g +: DW] = regs_q[g];
   end

endmodule

// File: tb/tb_pspl_axil_regs.sv
// Directed bench for pspl_axil_regs: a 4-register and a 3-register instance share one AXI master,
// with expected responses queued at drive time and popped when the response appears.
module tb_pspl_axil_regs;

   logic        clk;
   logic        areset;
   logic [3:0]  awaddr, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   logic        awready4, wready4, bvalid4, arready4, rvalid4;
   logic [1:0]  bresp4, rresp4;
   logic [31:0] rdata4;
   logic [127:0] regs4;
   logic [3:0]  pulse4;
   logic [1:0]  wst4;
   logic        rst4;

   logic        awready3, wready3, bvalid3, arready3, rvalid3;
   logic [1:0]  bresp3, rresp3;
   logic [31:0] rdata3;
   logic [95:0] regs3;
   logic [2:0]  pulse3;
   logic [1:0]  wst3;
   logic        rst3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m4 [4];
   logic [31:0] m3 [3];
   logic [1:0]  exp_b4_q [$];
   logic [1:0]  exp_b3_q [$];
   logic [33:0] exp_r4_q [$];
   logic [33:0] exp_r3_q [$];

   pspl_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(4)) dut4 (
      .s00_axi_aclk(clk), .s00_axi_areset(areset),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready4),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready4),
      .s00_axi_bresp(bresp4), .s00_axi_bvalid(bvalid4), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready4),
      .s00_axi_rdata(rdata4), .s00_axi_rresp(rresp4), .s00_axi_rvalid(rvalid4), .s00_axi_rready(rready),
      .regs_out(regs4), .wr_pulse(pulse4), .dbg_wr_state_o(wst4), .dbg_rd_state_o(rst4));

   pspl_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut3 (
      .s00_axi_aclk(clk), .s00_axi_areset(areset),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b101), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready3),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready3),
      .s00_axi_bresp(bresp3), .s00_axi_bvalid(bvalid3), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(3'b010), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready3),
      .s00_axi_rdata(rdata3), .s00_axi_rresp(rresp3), .s00_axi_rvalid(rvalid3), .s00_axi_rready(rready),
      .regs_out(regs3), .wr_pulse(pulse3), .dbg_wr_state_o(wst3), .dbg_rd_state_o(rst3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] model4();
      return {m4[3], m4[2], m4[1], m4[0]};
   endfunction

   function automatic logic [95:0] model3();
      return {m3[2], m3[1], m3[0]};
   endfunction

   task automatic push_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int idx;
      idx = int'(addr[3:2]);
      exp_b4_q.push_back(2'b00);
      exp_b3_q.push_back((idx < 3) ? 2'b00 : 2'b10);
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            m4[idx][8*b +: 8] = data[8*b +: 8];
            if (idx < 3) m3[idx][8*b +: 8] = data[8*b +: 8];
         end
      end
   endtask

   task automatic push_rd(input logic [3:0] addr);
      int idx;
      idx = int'(addr[3:2]);
      exp_r4_q.push_back({2'b00, m4[idx]});
      exp_r3_q.push_back((idx < 3) ? {2'b00, m3[idx]} : {2'b10, 32'h0});
   endtask

   task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly);
      int   c, idx;
      logic aw_done, w_done, aw_fire, w_fire;
      logic [3:0] exp_p4;
      logic [2:0] exp_p3;
      logic [1:0] eb4, eb3;
      idx    = int'(addr[3:2]);
      exp_p4 = 4'(1 << idx);
      exp_p3 = (idx < 3) ? 3'(1 << idx) : 3'b000;
      push_wr(addr, data, strb);
      awaddr = addr; wdata = data; wstrb = strb;
      aw_done = 1'b0; w_done = 1'b0; c = 0;
      while (!(aw_done && w_done) && c < 50) begin
         awvalid = !aw_done && (c >= aw_dly);
         wvalid  = !w_done && (c >= w_dly);
         aw_fire = awvalid && awready4;
         w_fire  = wvalid && wready4;
         if (aw_done && !w_done) begin
            check("awready_low_after_aw", awready4, 1'b0);
            check("no_bvalid_before_w", bvalid4, 1'b0);
         end
         if (w_done && !aw_done) begin
            check("wready_low_after_w", wready4, 1'b0);
            check("no_bvalid_before_aw", bvalid4, 1'b0);
         end
         @(posedge clk); @(negedge clk);
         if (aw_fire) aw_done = 1'b1;
         if (w_fire)  w_done  = 1'b1;
         c++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_handshakes_done", aw_done && w_done, 1'b1);
      eb4 = exp_b4_q.pop_front();
      eb3 = exp_b3_q.pop_front();
      check("bvalid4_next_cycle", bvalid4, 1'b1);
      check("bresp4", bresp4, eb4);
      check("bvalid3_next_cycle", bvalid3, 1'b1);
      check("bresp3", bresp3, eb3);
      check("wr_pulse4", pulse4, exp_p4);
      check("wr_pulse3", pulse3, exp_p3);
      check("regs_out4", regs4, model4());
      check("regs_out3", regs3, model3());
      bready = 1'b1;
      @(posedge clk); @(negedge clk);
      bready = 1'b0;
      check("bvalid4_cleared", bvalid4, 1'b0);
      check("wr_pulse4_one_cycle", pulse4, 4'b0000);
      check("wr_pulse3_one_cycle", pulse3, 3'b000);
   endtask

   task automatic do_read(input logic [3:0] addr);
      int   c;
      logic fire;
      logic [33:0] e4, e3;
      push_rd(addr);
      araddr = addr; arvalid = 1'b1;
      fire = 1'b0; c = 0;
      while (!fire && c < 50) begin
         fire = arready4;
         @(posedge clk); @(negedge clk);
         c++;
      end
      arvalid = 1'b0;
      check("ar_handshake_done", fire, 1'b1);
      e4 = exp_r4_q.pop_front();
      e3 = exp_r3_q.pop_front();
      check("rvalid4", rvalid4, 1'b1);
      check("rdata4", rdata4, e4[31:0]);
      check("rresp4", rresp4, e4[33:32]);
      check("rvalid3", rvalid3, 1'b1);
      check("rdata3", rdata3, e3[31:0]);
      check("rresp3", rresp3, e3[33:32]);
      rready = 1'b1;
      @(posedge clk); @(negedge clk);
      rready = 1'b0;
      check("rvalid4_cleared", rvalid4, 1'b0);
   endtask

   task automatic check_reset_state();
      check("rst_awready", awready4, 1'b0);
      check("rst_wready", wready4, 1'b0);
      check("rst_arready", arready4, 1'b0);
      check("rst_bvalid", bvalid4, 1'b0);
      check("rst_rvalid", rvalid4, 1'b0);
      check("rst_bresp", bresp4, 2'b00);
      check("rst_rresp", rresp4, 2'b00);
      check("rst_rdata", rdata4, 32'h0);
      check("rst_regs4", regs4, 128'h0);
      check("rst_regs3", regs3, 96'h0);
      check("rst_pulse4", pulse4, 4'b0);
   endtask

   initial begin
      logic [1:0]  eb4, eb3;
      logic [33:0] er4, er3;
      areset = 1'b1;
      awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      for (int i = 0; i < 4; i++) m4[i] = '0;
      for (int i = 0; i < 3; i++) m3[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state();
      areset = 1'b0;
      @(posedge clk); @(negedge clk);

      // Basic write of all four registers, then read back.
      for (int i = 0; i < 4; i++) do_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
      for (int i = 0; i < 4; i++) do_read(4'(4 * i));
      check("regs_out_concat", regs4, 128'h00000004_00000003_00000002_00000001);

      // AW ahead of W, then W ahead of AW; the low address bits are ignored.
      do_write(4'h0, 32'hA5A5_0001, 4'hF, 0, 3);
      do_write(4'h7, 32'h5A5A_0002, 4'hF, 3, 0);
      do_read(4'h0);
      do_read(4'h5);

      // Byte strobes.
      do_write(4'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
      do_write(4'h4, 32'h1234_5678, 4'b0101, 0, 0);
      do_read(4'h4);
      check("strobe_merge", regs4[63:32], 32'hFF34_FF78);

      // Empty strobe still completes with OKAY and a pulse.
      do_write(4'h8, 32'hFFFF_FFFF, 4'b0000, 1, 1);
      check("zero_strobe_keeps_reg2", regs4[95:64], 32'h0000_0003);

      // Concurrent write and read of reg0 on one edge, with both responses back-pressured.
      push_rd(4'h0);
      push_wr(4'h0, 32'hCAFE_0005, 4'hF);
      awaddr = 4'h0; wdata = 32'hCAFE_0005; wstrb = 4'hF; araddr = 4'h0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      eb4 = exp_b4_q.pop_front(); eb3 = exp_b3_q.pop_front();
      er4 = exp_r4_q.pop_front(); er3 = exp_r3_q.pop_front();
      check("conc_bvalid", bvalid4, 1'b1);
      check("conc_rvalid", rvalid4, 1'b1);
      check("conc_rdata_prewrite", rdata4, er4[31:0]);
      check("conc_rdata3_prewrite", rdata3, er3[31:0]);
      check("conc_bresp3", bresp3, eb3);
      check("conc_pulse", pulse4, 4'b0001);
      awaddr = 4'h4; awvalid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); @(negedge clk);
         check("hold_bvalid", bvalid4, 1'b1);
         check("hold_bresp", bresp4, eb4);
         check("hold_awready", awready4, 1'b0);
         check("hold_wready", wready4, 1'b0);
         if (k <= 4) begin
            check("hold_rvalid", rvalid4, 1'b1);
            check("hold_rdata", rdata4, er4[31:0]);
            check("hold_rresp", rresp4, er4[33:32]);
            check("hold_arready", arready4, 1'b0);
            if (k == 4) rready = 1'b1;
         end else begin
            rready = 1'b0;
            check("rvalid_after_rready", rvalid4, 1'b0);
            check("arready_after_rready", arready4, 1'b1);
         end
      end
      bready = 1'b1;
      @(posedge clk); @(negedge clk);
      bready = 1'b0;
      check("bvalid_after_bready", bvalid4, 1'b0);
      check("awready_after_bready", awready4, 1'b1);
      check("regs_after_conc", regs4, model4());
      do_write(4'h4, 32'h0BAD_0006, 4'hF, 0, 0);

      // Out-of-range register on the 3-register instance.
      do_write(4'hC, 32'h0000_DEAD, 4'hF, 0, 0);
      do_read(4'hC);
      check("slverr_regs3_unchanged", regs3[95:64], 32'h0000_0003);

      // Reset while holding only an address.
      awaddr = 4'h0; awvalid = 1'b1; wdata = 32'h7777_7777; wstrb = 4'hF;
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0;
      check("have_aw_awready", awready4, 1'b0);
      check("have_aw_wready", wready4, 1'b1);
      areset = 1'b1;
      @(posedge clk); @(negedge clk);
      check_reset_state();
      areset = 1'b0;
      for (int i = 0; i < 4; i++) m4[i] = '0;
      for (int i = 0; i < 3; i++) m3[i] = '0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); @(negedge clk);
         check("no_bvalid_after_abort", bvalid4, 1'b0);
      end
      do_read(4'h0);
      check("regs4_zero_after_reset", regs4, 128'h0);
      check("regs3_zero_after_reset", regs3, 96'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pspl_axil_regs.md
Name: pspl_axil_regs

Overview:
AXI4-Lite slave register bank for the PS-PL interface. It sits directly downstream of the PS AXI master (VIP master in simulation) on the S00_AXI port. It provides NUM_REGS 32-bit read/write configuration registers to the PL acoustic-processing logic, and a one-cycle write pulse per register. The write and read channels run independent state machines with a single outstanding transaction each.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, byte address width; register index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers; 1 to 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
s00_axi_aclk  in  1  clock
s00_axi_areset  in  1  reset, synchronous, active-high
s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
regs_out  out  NUM_REGS*32  register contents; reg i at [32*i+31:32*i]
wr_pulse  out  NUM_REGS  one-cycle strobe when reg i is written

Behaviour:
- Reset (s00_axi_areset=1 at a rising edge): all registers=0, regs_out=0, wr_pulse=0, awready=wready=bvalid=arready=rvalid=0, bresp=rresp=0, rdata=0. Both FSMs go to IDLE.
- Reset asserted mid-transaction aborts it. No response is issued, and a write not yet committed does not update the register.
- Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_W. wready=1 in W_IDLE and W_HAVE_AW. Both are 0 in W_RESP.
  - W_IDLE: AW only -> latch address, go to W_HAVE_AW. W only -> latch data and strobe, go to W_HAVE_W. Both in the same cycle -> commit, go to W_RESP.
  - W_HAVE_AW + W handshake -> commit, go to W_RESP. W_HAVE_W + AW handshake -> commit, go to W_RESP.
  - Commit edge: for each byte b with wstrb[b]=1, reg[idx][8b+7:8b] <= wdata byte. From the next cycle: bvalid=1, wr_pulse[idx]=1 for exactly one cycle, bresp=OKAY(00).
  - If idx >= NUM_REGS: no register changes, no wr_pulse, bresp=SLVERR(10).
  - W_RESP: hold bvalid and bresp stable until bready=1. On that edge bvalid=0 and the FSM returns to W_IDLE. Minimum write latency: AW+W in cycle N -> bvalid in cycle N+1.
- Read FSM states: R_IDLE, R_RESP.
  - arready=1 only in R_IDLE.
  - AR handshake in cycle N -> rdata=reg[idx] (value at edge N) and rvalid=1 in cycle N+1, rresp=OKAY.
  - If idx >= NUM_REGS: rdata=0, rresp=SLVERR.
  - Hold rvalid, rdata and rresp stable until rready=1, then return to R_IDLE. arready rises the following cycle.
- Read and write are fully independent. If a read AR handshake and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- wstrb=0000: a valid transaction with OKAY response, no data change, and wr_pulse still asserted.
- regs_out is a direct view of register storage. It updates the cycle after commit, coincident with the wr_pulse rise.
- awaddr[1:0] and araddr[1:0] are ignored. awprot and arprot are ignored.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back -> rdata 0x1..0x4 in order, all resp OKAY, wr_pulse bits 0..3 each high exactly one cycle, regs_out=0x00000004_00000003_00000002_00000001.
- awvalid 3 cycles before wvalid, then the reverse order -> awready drops after AW capture, commit only after W, bvalid exactly one cycle after the second handshake, stored data correct.
- reg1=0xFFFFFFFF, then write 0x12345678 with wstrb=0101 to 0x4 -> read 0xFF34FF78.
- Hold bready=0 for 5 cycles after commit -> bvalid and bresp stable, awready=wready=0 throughout, a second AW waits. Concurrently, a read of reg0 with rready=0 for 4 cycles -> rdata held and arready=0.
- NUM_REGS=3: write 0xDEAD to 0xC, then read 0xC -> bresp=10, rresp=10, rdata=0, regs_out unchanged, no wr_pulse.
- Assert s00_axi_areset while in W_HAVE_AW (W not yet sent), release, read 0x0 -> bvalid never asserted, rdata=0, all registers 0.
